// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word req/ack controller for the 32-bit asynchronous base SRAM.
// Every pin and status output is registered; the data bus is driven from a registered enable.
module sram_ctrl #(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [19:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n
);
    localparam int MAXC = READ_CYCLES > WRITE_CYCLES ? READ_CYCLES : WRITE_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [19:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [3:0]    be_n_q;
    logic          ce_n_q;
    logic          oe_n_q;
    logic          we_n_q;
    logic          drive_q;
    logic          ack_q;
    logic          busy_q;

    assign base_ram_data = drive_q ? wdata_q : 32'bz;
    assign base_ram_addr = addr_q;
    assign base_ram_be_n = be_n_q;
    assign base_ram_ce_n = ce_n_q;
    assign base_ram_oe_n = oe_n_q;
    assign base_ram_we_n = we_n_q;
    assign rdata = rdata_q;
    assign ack = ack_q;
    assign busy = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_n_q <= 4'hF;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            drive_q <= 1'b0;
            ack_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: if (req) begin
                    state_q <= we ? WSETUP : RD;
                    addr_q <= addr;
                    wdata_q <= wdata;
                    be_n_q <= we ? ~be : 4'h0;
                    ce_n_q <= 1'b0;
                    oe_n_q <= we;
                    drive_q <= we;
                    busy_q <= 1'b1;
                    cnt_q <= '0;
                end
                RD: if (cnt_q == CW'(READ_CYCLES - 1)) begin
                    rdata_q <= base_ram_data;
                    ce_n_q <= 1'b1;
                    oe_n_q <= 1'b1;
                    be_n_q <= 4'hF;
                    ack_q <= 1'b1;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                // address and data were settled a cycle earlier, so we_n can fall cleanly
                WSETUP: begin
                    we_n_q <= 1'b0;
                    state_q <= WPULSE;
                end
                WPULSE: if (cnt_q == CW'(WRITE_CYCLES - 1)) begin
                    we_n_q <= 1'b1;
                    state_q <= WHOLD;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                WHOLD: begin
                    ce_n_q <= 1'b1;
                    be_n_q <= 4'hF;
                    drive_q <= 1'b0;
                    ack_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: random and directed checks of sram_ctrl against a transaction-offset model
// and a behavioural SRAM, plus a second instance with READ_CYCLES=1, WRITE_CYCLES=4.
module tb_sram_ctrl;
    localparam int RC = 2;
    localparam int WC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    logic req = 1'b0, we = 1'b0;
    logic [19:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0] be = '0;
    logic [31:0] rdata;
    logic ack, busy, ce_n, oe_n, we_n;
    logic [19:0] ba;
    logic [3:0] bben;
    wire [31:0] bd;

    logic req2 = 1'b0, we2 = 1'b0;
    logic [19:0] addr2 = '0;
    logic [31:0] wdata2 = '0;
    logic [3:0] be2 = '0;
    logic [31:0] rdata2;
    logic ack2, busy2, ce_n2, oe_n2, we_n2;
    logic [19:0] ba2;
    logic [3:0] bben2;
    wire [31:0] bd2;

    always #5 clk = ~clk;

    sram_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata), .ack(ack), .busy(busy), .base_ram_data(bd), .base_ram_addr(ba),
        .base_ram_be_n(bben), .base_ram_ce_n(ce_n), .base_ram_oe_n(oe_n), .base_ram_we_n(we_n)
    );

    sram_ctrl #(.READ_CYCLES(1), .WRITE_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2), .be(be2),
        .rdata(rdata2), .ack(ack2), .busy(busy2), .base_ram_data(bd2), .base_ram_addr(ba2),
        .base_ram_be_n(bben2), .base_ram_ce_n(ce_n2), .base_ram_oe_n(oe_n2), .base_ram_we_n(we_n2)
    );

    // behavioural SRAMs: drive on ce_n&oe_n low, write enabled bytes at each edge with ce_n&we_n low
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [31:0] mem2 [256] = '{default: 32'h0};
    assign bd = (!ce_n && !oe_n) ? mem[ba[7:0]] : 32'bz;
    assign bd2 = (!ce_n2 && !oe_n2) ? mem2[ba2[7:0]] : 32'bz;

    always @(posedge clk) begin
        if (!ce_n && !we_n)
            for (int b = 0; b < 4; b++) if (!bben[b]) mem[ba[7:0]][b*8 +: 8] <= bd[b*8 +: 8];
        if (!ce_n2 && !we_n2)
            for (int b = 0; b < 4; b++) if (!bben2[b]) mem2[ba2[7:0]][b*8 +: 8] <= bd2[b*8 +: 8];
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
        end
    endtask

    // model: k = cycle offset since the sampling edge (0 = idle)
    int k = 0;
    logic m_we = 1'b0;
    logic [19:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic [3:0] m_be = '0;
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0;
            m_addr = '0;
            m_rdata = '0;
        end else if (k == 0) begin
            if (req) begin
                k = 1;
                m_we = we;
                m_addr = addr;
                m_wdata = wdata;
                m_be = be;
            end
        end else begin
            if (!m_we && k == RC) m_rdata = ref_mem[m_addr[7:0]];
            if (m_we && k == 2)
                for (int b = 0; b < 4; b++) if (m_be[b]) ref_mem[m_addr[7:0]][b*8 +: 8] = m_wdata[b*8 +: 8];
            k = (k == (m_we ? WC + 3 : RC + 1)) ? 0 : k + 1;
        end
    end

    logic [55:0] prev = '0;
    logic [55:0] prev2 = '0;
    int wl2 = 0;

    always @(negedge clk) begin
        logic [8:0] e;
        logic act;
        act = !rst && k > 0 && k <= (m_we ? WC + 2 : RC);
        e = {3'b111, 4'hF, 2'b00};
        if (!rst && k > 0)
            e = act ? {1'b0, m_we, !(m_we && k > 1 && k <= WC + 1), m_we ? ~m_be : 4'h0, 2'b01}
                    : {3'b111, 4'hF, 2'b11};
        chk("ctrl", {ce_n, oe_n, we_n, bben, ack, busy}, e);
        chk("rdata", rdata, m_rdata);
        if (act || rst) chk("addr", ba, m_addr);
        if (act && m_we) chk("wbus", bd, m_wdata);
        if (!oe_n) chk("rbus", bd, mem[ba[7:0]]);
        if (!we_n) chk("we_stable", {ba, bd, bben, oe_n}, {prev, 1'b1});
        prev = {ba, bd, bben};
        if (!oe_n2) chk("rbus2", bd2, mem2[ba2[7:0]]);
        if (!we_n2) begin
            wl2++;
            chk("we_stable2", {ba2, bd2, bben2, oe_n2}, {prev2, 1'b1});
        end
        prev2 = {ba2, bd2, bben2};
    end

    task automatic txn(input bit s, input int gap, input logic w, input logic [19:0] a,
                       input logic [31:0] d, input logic [3:0] b, output logic [31:0] rd, output int lat);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        if (s) begin
            req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; be2 = b;
        end else begin
            req = 1'b1; we = w; addr = a; wdata = d; be = b;
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(s ? ack2 : ack) && lat < 40);
        rd = s ? rdata2 : rdata;
        req = 1'b0;
        req2 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat, g, w0, wl;
        logic w;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pins", {ce_n, oe_n, we_n, bben, ba}, {3'b111, 4'hF, 20'h0});
        chk("rst_status", {ack, busy, rdata}, 34'h0);
        chk("rst_pins2", {ce_n2, oe_n2, we_n2, bben2, ack2, busy2}, {3'b111, 4'hF, 2'b00});
        rst = 1'b0;

        txn(0, 1, 1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, rd, lat);
        chk("wr_lat", lat, 5);
        txn(0, 1, 1'b0, 20'h00010, 32'h0, 4'h0, rd, lat);
        chk("rd_lat", lat, 3);
        chk("rd_data", rd, 32'hDEADBEEF);

        txn(0, 1, 1'b1, 20'h00020, 32'h11223344, 4'hF, rd, lat);
        txn(0, 1, 1'b1, 20'h00020, 32'hAABBCCDD, 4'b0101, rd, lat);
        txn(0, 1, 1'b0, 20'h00020, 32'h0, 4'h0, rd, lat);
        chk("be_data", rd, 32'h11BB33DD);
        txn(0, 1, 1'b1, 20'h00030, 32'hFFFFFFFF, 4'h0, rd, lat);
        chk("be0_lat", lat, 5);
        txn(0, 1, 1'b0, 20'h00030, 32'h0, 4'h0, rd, lat);
        chk("be0_data", rd, 32'h0);

        txn(0, 1, 1'b1, 20'h00001, 32'h1, 4'hF, rd, lat);
        txn(0, 0, 1'b1, 20'h00002, 32'h2, 4'hF, rd, lat);
        chk("b2b_wr_int", lat, 6);
        txn(0, 0, 1'b0, 20'h00001, 32'h0, 4'h0, rd, lat);
        chk("b2b_rd_int", lat, 4);
        chk("b2b_rd1", rd, 32'h1);
        txn(0, 0, 1'b0, 20'h00002, 32'h0, 4'h0, rd, lat);
        chk("b2b_rd2", rd, 32'h2);

        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 20'h00005; wdata = 32'hCAFEF00D; be = 4'hF;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_rst_we", we_n, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_strobes", {ce_n, oe_n, we_n, bben}, {3'b111, 4'hF});
        chk("abort_status", {ack, busy}, 2'b00);
        @(posedge clk);
        #1;
        chk("abort_noack", ack, 1'b0);
        rst = 1'b0;
        txn(0, 1, 1'b0, 20'h00005, 32'h0, 4'h0, rd, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rd, 32'hCAFEF00D);

        for (int i = 0; i < 60; i++) begin
            g = $urandom_range(0, 2);
            w = 1'($urandom_range(0, 1));
            txn(0, g, w, 20'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), rd, lat);
            chk("rand_lat", lat, (w ? WC + 3 : RC + 1) + (g == 0 ? 1 : 0));
        end

        w0 = wl2;
        txn(1, 1, 1'b1, 20'h00003, 32'h12345678, 4'hF, rd, lat);
        wl = wl2 - w0;
        chk("p_wr_lat", lat, 7);
        chk("p_we_low", wl, 4);
        txn(1, 1, 1'b0, 20'h00003, 32'h0, 4'h0, rd, lat);
        chk("p_rd_lat", lat, 2);
        chk("p_rd_data", rd, 32'h12345678);
        txn(1, 0, 1'b0, 20'h00003, 32'h0, 4'h0, rd, lat);
        chk("p_b2b_int", lat, 3);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
